// File: rtl/load_store_pkg.sv
// Purpose: shared defaults and the arbiter mode/state encoding for the load/store arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package load_store_pkg;

  localparam int N_DEF     = 1250;  // volume capacity (full level)
  localparam int CBITS_DEF = 11;    // volume width, 2**CBITS > N
  localparam int BURST_DEF = 16;    // max grant length while the other side waits

  // Encoding is visible on the mode output: IDLE=0, FILL=1, DRAIN=2; 3 unused.
  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_FILL  = 2'd1,
    MODE_DRAIN = 2'd2
  } mode_t;

endpackage

// File: rtl/load_store_arbiter_if.sv
// Purpose: request/grant bundle between fill/drain requesters and the arbiter, plus volume status.
// Latency: wires only.
// Backpressure: grants are the only flow control; requests are level-sensitive.
// Ports: fill_req/drain_req (requesters -> arbiter); fill_gnt/drain_gnt, vol, full, empty, mode
//        (arbiter -> requesters).
interface load_store_arbiter_if
  import load_store_pkg::*;
#(
  parameter int CBITS = CBITS_DEF
) ();

  logic             fill_req;
  logic             drain_req;
  logic             fill_gnt;
  logic             drain_gnt;
  logic [CBITS-1:0] vol;
  logic             full;
  logic             empty;
  mode_t            mode;

  // Requester side.
  modport master (
    output fill_req, drain_req,
    input  fill_gnt, drain_gnt, vol, full, empty, mode
  );

  // Arbiter side.
  modport slave (
    input  fill_req, drain_req,
    output fill_gnt, drain_gnt, vol, full, empty, mode
  );

endinterface

// File: rtl/load_store_arbiter_vol_counter.sv
// Purpose: saturating up/down volume counter with full/empty decode.
// Latency: vol updates one clk after inc/dec; full/empty are combinational from registered vol.
// Backpressure: inc at N and dec at 0 are ignored (no wrap).
// Ports: clk, rst (async active-low); inc, dec in; vol, full, empty out.
module vol_counter
  import load_store_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CBITS = CBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CBITS-1:0] vol,
  output logic             full,
  output logic             empty
);

  assign full  = (vol == CBITS'(N));
  assign empty = (vol == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vol <= '0;
    end else if (inc && !full) begin
      vol <= vol + 1'b1;
    end else if (dec && !empty) begin
      vol <= vol - 1'b1;
    end
  end

endmodule

// File: rtl/load_store_arbiter.sv
// Purpose: round-robin fill/drain arbiter with burst limit, turnaround cycle and volume tracking.
// Latency: request sampled in IDLE at edge t -> grant after t; first vol change at edge t+1.
// Backpressure: grant ends on request drop, full/empty, or BURST transfers while the other side waits.
// Ports: clk, rst (async active-low); bus (slave modport): fill_req, drain_req in;
//        fill_gnt, drain_gnt, vol, full, empty, mode out.
module load_store_arbiter
  import load_store_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CBITS = CBITS_DEF,
  parameter int BURST = BURST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  load_store_arbiter_if.slave bus
);

  localparam int            BW         = $clog2(BURST + 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(BURST);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

  mode_t         state_q, state_d;
  mode_t         last_q, last_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          inc, dec;
  logic          fill_ok, drain_ok;

  assign fill_ok  = bus.fill_req  && !bus.full;
  assign drain_ok = bus.drain_req && !bus.empty;
  assign bus.mode = state_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    inc     = 1'b0;
    dec     = 1'b0;
    case (state_q)
      MODE_IDLE: begin
        burst_d = '0;
        if (fill_ok && drain_ok) begin
          // Tie goes to whichever side did not win last time.
          state_d = (last_q == MODE_FILL) ? MODE_DRAIN : MODE_FILL;
        end else if (fill_ok) begin
          state_d = MODE_FILL;
        end else if (drain_ok) begin
          state_d = MODE_DRAIN;
        end
        if (state_d != MODE_IDLE) last_d = state_d;
      end
      MODE_FILL: begin
        if (!bus.fill_req || bus.full) begin
          state_d = MODE_IDLE;
        end else begin
          inc = 1'b1;
          if (burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
          // Count saturates at BURST, so a drain request arriving late still
          // ends the grant on the very next increment.
          if (bus.vol == CBITS'(N - 1)) begin
            state_d = MODE_IDLE;
          end else if (bus.drain_req && burst_q >= BURST_LAST) begin
            state_d = MODE_IDLE;
          end
        end
      end
      MODE_DRAIN: begin
        if (!bus.drain_req || bus.empty) begin
          state_d = MODE_IDLE;
        end else begin
          dec = 1'b1;
          if (burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
          if (bus.vol == CBITS'(1)) begin
            state_d = MODE_IDLE;
          end else if (bus.fill_req && burst_q >= BURST_LAST) begin
            state_d = MODE_IDLE;
          end
        end
      end
      default: state_d = MODE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= MODE_IDLE;
      last_q        <= MODE_DRAIN;  // fill wins the first tie
      burst_q       <= '0;
      bus.fill_gnt  <= 1'b0;
      bus.drain_gnt <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      burst_q       <= burst_d;
      bus.fill_gnt  <= (state_d == MODE_FILL);
      bus.drain_gnt <= (state_d == MODE_DRAIN);
    end
  end

  vol_counter #(
    .N     (N),
    .CBITS (CBITS)
  ) u_vol (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .dec   (dec),
    .vol   (bus.vol),
    .full  (bus.full),
    .empty (bus.empty)
  );

endmodule

// File: tb/tb_load_store_arbiter.sv
// Purpose: directed self-checking bench for load_store_arbiter.
// Latency: n/a.
// Backpressure: n/a.
module tb_load_store_arbiter;
  import load_store_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   overlap_cnt = 0;
  int   mode3_cnt   = 0;

  load_store_arbiter_if #(.CBITS(11)) bus ();

  load_store_arbiter #(
    .N     (1250),
    .CBITS (11),
    .BURST (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && bus.fill_gnt && bus.drain_gnt) overlap_cnt++;
    if (rst && bus.mode == 2'd3) mode3_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst           = 1'b0;
    bus.fill_req  = 1'b0;
    bus.drain_req = 1'b0;

    // Reset state
    #3;
    chk("rst_vol",   32'(bus.vol),       0);
    chk("rst_mode",  32'(bus.mode),      0);
    chk("rst_fgnt",  32'(bus.fill_gnt),  0);
    chk("rst_dgnt",  32'(bus.drain_gnt), 0);
    chk("rst_full",  32'(bus.full),      0);
    chk("rst_empty", 32'(bus.empty),     1);

    // Fill from empty to full
    tick();
    rst          = 1'b1;
    bus.fill_req = 1'b1;
    tick();
    chk("fill_gnt_c1",  32'(bus.fill_gnt), 1);
    chk("fill_mode_c1", 32'(bus.mode),     1);
    chk("fill_vol_c1",  32'(bus.vol),      0);
    for (int i = 1; i <= 1250; i++) begin
      tick();
      if (i == 1)    chk("fill_vol_1", 32'(bus.vol), 1);
      if (i == 1249) begin
        chk("fill_vol_1249", 32'(bus.vol),      1249);
        chk("fill_gnt_1249", 32'(bus.fill_gnt), 1);
      end
    end
    chk("full_vol",  32'(bus.vol),      1250);
    chk("full_flag", 32'(bus.full),     1);
    chk("full_fgnt", 32'(bus.fill_gnt), 0);
    chk("full_mode", 32'(bus.mode),     0);
    ticks(3);
    chk("full_hold_fgnt", 32'(bus.fill_gnt), 0);
    chk("full_hold_mode", 32'(bus.mode),     0);
    chk("full_hold_vol",  32'(bus.vol),      1250);

    // Drain from full to empty
    bus.fill_req  = 1'b0;
    bus.drain_req = 1'b1;
    tick();
    chk("drain_gnt_c1", 32'(bus.drain_gnt), 1);
    chk("drain_vol_c1", 32'(bus.vol),       1250);
    ticks(1250);
    chk("empty_vol",  32'(bus.vol),       0);
    chk("empty_flag", 32'(bus.empty),     1);
    chk("empty_dgnt", 32'(bus.drain_gnt), 0);
    ticks(3);
    chk("empty_hold_dgnt", 32'(bus.drain_gnt), 0);
    chk("empty_hold_mode", 32'(bus.mode),      0);

    // Set up vol=100 with drain as last winner
    bus.drain_req = 1'b0;
    bus.fill_req  = 1'b1;
    tick();
    ticks(110);
    chk("pre_vol110",  32'(bus.vol),  110);
    chk("pre_mode110", 32'(bus.mode), 1);
    bus.fill_req = 1'b0;
    tick();
    chk("pre_drop_mode", 32'(bus.mode), 0);
    chk("pre_drop_vol",  32'(bus.vol),  110);
    bus.drain_req = 1'b1;
    tick();
    ticks(10);
    chk("pre_vol100", 32'(bus.vol), 100);
    bus.drain_req = 1'b0;
    tick();
    chk("pre_idle_mode", 32'(bus.mode), 0);

    // Both requesting: alternation with burst limit
    bus.fill_req  = 1'b1;
    bus.drain_req = 1'b1;
    tick();
    chk("rr_first_fill", 32'(bus.mode), 1);
    chk("rr_vol_start",  32'(bus.vol),  100);
    ticks(15);
    chk("rr_vol115",  32'(bus.vol),  115);
    chk("rr_mode115", 32'(bus.mode), 1);
    tick();
    chk("rr_vol116",     32'(bus.vol),  116);
    chk("rr_turn1_idle", 32'(bus.mode), 0);
    tick();
    chk("rr_drain_mode", 32'(bus.mode),      2);
    chk("rr_drain_gnt",  32'(bus.drain_gnt), 1);
    ticks(16);
    chk("rr_vol_back",   32'(bus.vol),  100);
    chk("rr_turn2_idle", 32'(bus.mode), 0);
    tick();
    chk("rr_fill_again", 32'(bus.mode), 1);
    bus.fill_req  = 1'b0;
    bus.drain_req = 1'b0;
    tick();
    chk("rr_stop_mode", 32'(bus.mode), 0);
    chk("rr_stop_vol",  32'(bus.vol),  100);

    // Fill request dropped for one cycle at vol=10
    bus.drain_req = 1'b1;
    tick();
    ticks(90);
    chk("gap_vol10", 32'(bus.vol), 10);
    bus.drain_req = 1'b0;
    tick();
    bus.fill_req = 1'b1;
    tick();
    chk("gap_fill_mode", 32'(bus.mode), 1);
    bus.fill_req = 1'b0;
    tick();
    chk("gap_vol_hold", 32'(bus.vol),      10);
    chk("gap_idle",     32'(bus.mode),     0);
    chk("gap_fgnt0",    32'(bus.fill_gnt), 0);
    bus.fill_req = 1'b1;
    tick();
    chk("gap_regrant", 32'(bus.fill_gnt), 1);
    chk("gap_vol_rg",  32'(bus.vol),      10);
    tick();
    chk("gap_vol11", 32'(bus.vol), 11);

    // Asynchronous reset mid-grant at vol=500
    ticks(489);
    chk("ar_vol500", 32'(bus.vol),      500);
    chk("ar_fgnt",   32'(bus.fill_gnt), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_vol0",  32'(bus.vol),      0);
    chk("ar_fgnt0", 32'(bus.fill_gnt), 0);
    chk("ar_mode0", 32'(bus.mode),     0);
    chk("ar_empty", 32'(bus.empty),    1);
    #2;
    rst = 1'b1;
    tick();
    chk("ar_resume_gnt", 32'(bus.fill_gnt), 1);
    chk("ar_resume_vol", 32'(bus.vol),      0);
    tick();
    chk("ar_resume_vol1", 32'(bus.vol), 1);

    bus.fill_req = 1'b0;
    ticks(2);
    chk("never_both_gnt", 32'(overlap_cnt), 0);
    chk("never_mode3",    32'(mode3_cnt),   0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
